// File: rtl/rows_resize_ctrl.sv
// Frame-geometry controller: shadowed row/line config applied at SOF, regenerated tuser/tlast,
// out-of-frame beat dropping, frame_done / sof_err / cfg_err pulses. All outputs registered, 1-cycle latency.
module rows_resize_ctrl #(
   parameter int          DATA_WIDTH = 8,
   parameter logic [11:0] DEF_ROWS   = 12'd3840,
   parameter logic [11:0] DEF_LINES  = 12'd2160
) (
   input  logic                  pixel_clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cfg_wr,
   input  logic [11:0]           cfg_rows_size,
   input  logic [11:0]           cfg_lines,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   output logic [11:0]           active_rows,
   output logic [11:0]           active_lines,
   output logic                  cfg_pending,
   output logic                  cfg_err,
   output logic                  frame_done,
   output logic                  sof_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [11:0]           pix_cnt_q, pix_cnt_d;
   logic [11:0]           line_cnt_q, line_cnt_d;
   logic [11:0]           shadow_rows_q, shadow_rows_d;
   logic [11:0]           shadow_lines_q, shadow_lines_d;
   logic [11:0]           active_rows_q, active_rows_d;
   logic [11:0]           active_lines_q, active_lines_d;
   logic                  cfg_pending_q, cfg_pending_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  frame_done_q, frame_done_d;
   logic                  sof_err_q, sof_err_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tuser_q, tuser_d;
   logic                  tlast_q, tlast_d;
   logic                  tvalid_q, tvalid_d;
   logic                  start;
   logic                  line_end;

   always_comb begin
      state_d        = state_q;
      pix_cnt_d      = pix_cnt_q;
      line_cnt_d     = line_cnt_q;
      shadow_rows_d  = shadow_rows_q;
      shadow_lines_d = shadow_lines_q;
      active_rows_d  = active_rows_q;
      active_lines_d = active_lines_q;
      cfg_pending_d  = cfg_pending_q;
      cfg_err_d      = 1'b0;
      frame_done_d   = 1'b0;
      sof_err_d      = 1'b0;
      tdata_d        = tdata_q;
      tuser_d        = 1'b0;
      tlast_d        = 1'b0;
      tvalid_d       = 1'b0;
      start          = 1'b0;
      line_end       = (pix_cnt_q == active_rows_q - 12'd1);

      case (state_q)
         IDLE: begin
            if (s_axis_tvalid && s_axis_tuser && enable) start = 1'b1;
         end
         RUN: begin
            if (s_axis_tvalid) begin
               if (s_axis_tuser) begin
                  if (pix_cnt_q != 12'd0 || line_cnt_q != 12'd0) sof_err_d = 1'b1;
                  if (enable) begin
                     start = 1'b1;
                  end else begin
                     state_d    = IDLE;
                     pix_cnt_d  = 12'd0;
                     line_cnt_d = 12'd0;
                  end
               end else begin
                  tvalid_d = 1'b1;
                  tdata_d  = s_axis_tdata;
                  tlast_d  = line_end;
                  if (line_end) begin
                     pix_cnt_d = 12'd0;
                     if (line_cnt_q == active_lines_q - 12'd1) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        line_cnt_d   = 12'd0;
                     end else begin
                        line_cnt_d = line_cnt_q + 12'd1;
                     end
                  end else begin
                     pix_cnt_d = pix_cnt_q + 12'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The SOF beat is position 0 and is emitted here; rows>=2 means it can never be a line end.
      if (start) begin
         state_d        = RUN;
         active_rows_d  = shadow_rows_q;
         active_lines_d = shadow_lines_q;
         cfg_pending_d  = 1'b0;
         pix_cnt_d      = 12'd1;
         line_cnt_d     = 12'd0;
         tvalid_d       = 1'b1;
         tuser_d        = 1'b1;
         tdata_d        = s_axis_tdata;
      end

      // Evaluated after the SOF load so a same-cycle write stays pending for the next frame.
      if (cfg_wr) begin
         if (cfg_rows_size >= 12'd2 && cfg_lines >= 12'd1) begin
            shadow_rows_d  = cfg_rows_size;
            shadow_lines_d = cfg_lines;
            cfg_pending_d  = 1'b1;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pix_cnt_q      <= 12'd0;
         line_cnt_q     <= 12'd0;
         shadow_rows_q  <= DEF_ROWS;
         shadow_lines_q <= DEF_LINES;
         active_rows_q  <= DEF_ROWS;
         active_lines_q <= DEF_LINES;
         cfg_pending_q  <= 1'b0;
         cfg_err_q      <= 1'b0;
         frame_done_q   <= 1'b0;
         sof_err_q      <= 1'b0;
         tdata_q        <= '0;
         tuser_q        <= 1'b0;
         tlast_q        <= 1'b0;
         tvalid_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pix_cnt_q      <= pix_cnt_d;
         line_cnt_q     <= line_cnt_d;
         shadow_rows_q  <= shadow_rows_d;
         shadow_lines_q <= shadow_lines_d;
         active_rows_q  <= active_rows_d;
         active_lines_q <= active_lines_d;
         cfg_pending_q  <= cfg_pending_d;
         cfg_err_q      <= cfg_err_d;
         frame_done_q   <= frame_done_d;
         sof_err_q      <= sof_err_d;
         tdata_q        <= tdata_d;
         tuser_q        <= tuser_d;
         tlast_q        <= tlast_d;
         tvalid_q       <= tvalid_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign active_rows   = active_rows_q;
   assign active_lines  = active_lines_q;
   assign cfg_pending   = cfg_pending_q;
   assign cfg_err       = cfg_err_q;
   assign frame_done    = frame_done_q;
   assign sof_err       = sof_err_q;

endmodule

// File: tb/tb_rows_resize_ctrl.sv
// Bench for rows_resize_ctrl: hand-computed vector table, directed corner sequences,
// and a randomized run against a beat-index reference model.
module tb_rows_resize_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [11:0] cfg_rows_size = '0;
   logic [11:0] cfg_lines = '0;
   logic [7:0]  s_tdata = '0;
   logic        s_tuser = 1'b0;
   logic        s_tvalid = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tuser, m_tlast, m_tvalid;
   logic [11:0] act_rows, act_lines;
   logic        pend, cerr, fdone, serr;

   int checks = 0;
   int errors = 0;

   rows_resize_ctrl #(.DATA_WIDTH(8), .DEF_ROWS(12'd3840), .DEF_LINES(12'd2160)) dut (
      .pixel_clk(clk), .rst(rst), .enable(enable), .cfg_wr(cfg_wr),
      .cfg_rows_size(cfg_rows_size), .cfg_lines(cfg_lines),
      .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
      .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .active_rows(act_rows), .active_lines(act_lines),
      .cfg_pending(pend), .cfg_err(cerr), .frame_done(fdone), .sof_err(serr));

   always #5 clk = ~clk;

   // Reference model: a frame is a flat run of rows*lines beats indexed by k.
   bit       m_in;
   int       m_k, m_ar, m_al, m_sr, m_sl;
   bit       m_pend, m_vld, m_tu, m_tl, m_done, m_serr, m_cerr;
   logic [7:0] m_data;

   task automatic m_emit();
      m_vld  = 1;
      m_data = s_tdata;
      m_tl   = (m_k % m_ar) == m_ar - 1;
      m_done = (m_k == m_ar * m_al - 1);
      m_k++;
      if (m_done) m_in = 0;
   endtask

   task automatic m_start();
      m_ar = m_sr; m_al = m_sl; m_pend = 0; m_k = 0; m_in = 1;
      m_emit();
      m_tu = 1;
   endtask

   task automatic model_step();
      {m_vld, m_tu, m_tl, m_done, m_serr, m_cerr} = '0;
      if (rst) begin
         m_in = 0; m_k = 0; m_ar = 3840; m_al = 2160; m_sr = 3840; m_sl = 2160;
         m_pend = 0; m_data = '0;
         return;
      end
      if (!m_in) begin
         if (s_tvalid && s_tuser && enable) m_start();
      end else if (s_tvalid) begin
         if (s_tuser) begin
            if (m_k != 0) m_serr = 1;
            if (enable) m_start();
            else m_in = 0;
         end else begin
            m_emit();
         end
      end
      if (cfg_wr) begin
         if (cfg_rows_size >= 2 && cfg_lines >= 1) begin
            m_sr = int'(cfg_rows_size); m_sl = int'(cfg_lines); m_pend = 1;
         end else begin
            m_cerr = 1;
         end
      end
   endtask

   function automatic logic [38:0] dut_obs();
      return {m_tvalid, m_tuser, m_tlast, fdone, serr, cerr, pend, act_rows, act_lines, m_tdata};
   endfunction

   function automatic logic [38:0] model_obs();
      return {m_vld, m_tu, m_tl, m_done, m_serr, m_cerr, m_pend, 12'(m_ar), 12'(m_al), m_data};
   endfunction

   task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
      check(name, {7'd0, got}, {7'd0, exp});
   endtask

   // Inputs are driven at the falling edge; outputs are sampled at the next falling edge.
   task automatic drive(input logic r, input logic en, input logic wr, input logic [11:0] rows,
                        input logic [11:0] lines, input logic v, input logic u, input logic [7:0] d);
      rst = r; enable = en; cfg_wr = wr; cfg_rows_size = rows; cfg_lines = lines;
      s_tvalid = v; s_tuser = u; s_tdata = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", dut_obs(), model_obs());
   endtask

   task automatic beat(input logic en, input logic u, input logic [7:0] d);
      drive(1'b0, en, 1'b0, 12'd0, 12'd0, 1'b1, u, d);
   endtask

   task automatic cfg(input logic [11:0] rows, input logic [11:0] lines);
      drive(1'b0, 1'b1, 1'b1, rows, lines, 1'b0, 1'b0, 8'd0);
   endtask

   typedef struct {
      logic r, en, wr; logic [11:0] rows, lines; logic v, u; logic [7:0] d;
      logic [38:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic r, en, wr, input int rows, lines, input logic v, u,
                               input int d, input logic vld, tu, tl, dn, se, ce, pd,
                               input int ar, al, ed);
      vec_t t;
      t.r = r; t.en = en; t.wr = wr; t.rows = 12'(rows); t.lines = 12'(lines);
      t.v = v; t.u = u; t.d = 8'(d);
      t.exp = {vld, tu, tl, dn, se, ce, pd, 12'(ar), 12'(al), 8'(ed)};
      return t;
   endfunction

   initial begin
      vec_t tbl[16];
      logic [31:0] tl_mask, tu_mask, dn_mask;

      tbl[0]  = mk(1,0,0,0,0, 0,0,'h00, 0,0,0,0,0,0,0, 3840,2160,'h00);
      tbl[1]  = mk(0,1,1,2,2, 0,0,'h00, 0,0,0,0,0,0,1, 3840,2160,'h00);
      tbl[2]  = mk(0,1,1,1,2, 0,0,'h00, 0,0,0,0,0,1,1, 3840,2160,'h00);
      tbl[3]  = mk(0,1,0,0,0, 1,0,'h11, 0,0,0,0,0,0,1, 3840,2160,'h00);
      tbl[4]  = mk(0,1,0,0,0, 1,1,'h21, 1,1,0,0,0,0,0, 2,2,'h21);
      tbl[5]  = mk(0,1,0,0,0, 0,0,'h99, 0,0,0,0,0,0,0, 2,2,'h21);
      tbl[6]  = mk(0,1,0,0,0, 1,0,'h22, 1,0,1,0,0,0,0, 2,2,'h22);
      tbl[7]  = mk(0,1,0,0,0, 1,0,'h23, 1,0,0,0,0,0,0, 2,2,'h23);
      tbl[8]  = mk(0,1,0,0,0, 1,0,'h24, 1,0,1,1,0,0,0, 2,2,'h24);
      tbl[9]  = mk(0,1,0,0,0, 1,0,'h25, 0,0,0,0,0,0,0, 2,2,'h24);
      tbl[10] = mk(0,1,1,5,0, 0,0,'h00, 0,0,0,0,0,1,0, 2,2,'h24);
      tbl[11] = mk(0,1,1,3,1, 1,1,'h30, 1,1,0,0,0,0,1, 2,2,'h30);
      tbl[12] = mk(0,1,0,0,0, 1,1,'h31, 1,1,0,0,1,0,0, 3,1,'h31);
      tbl[13] = mk(0,1,0,0,0, 1,0,'h32, 1,0,0,0,0,0,0, 3,1,'h32);
      tbl[14] = mk(0,1,0,0,0, 1,0,'h33, 1,0,1,1,0,0,0, 3,1,'h33);
      tbl[15] = mk(0,0,0,0,0, 1,1,'h40, 0,0,0,0,0,0,0, 3,1,'h33);

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].r, tbl[i].en, tbl[i].wr, tbl[i].rows, tbl[i].lines, tbl[i].v, tbl[i].u, tbl[i].d);
         check($sformatf("vec%0d", i), dut_obs(), tbl[i].exp);
      end

      // 8x4 frame of 32 beats.
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      cfg(12'd8, 12'd4);
      tl_mask = '0; tu_mask = '0; dn_mask = '0;
      for (int i = 0; i < 32; i++) begin
         beat(1'b1, i == 0, 8'(i + 1));
         tl_mask[i] = m_tlast; tu_mask[i] = m_tuser; dn_mask[i] = fdone;
      end
      check1("frame_tlast", tl_mask, 32'h8080_8080);
      check1("frame_tuser", tu_mask, 32'h0000_0001);
      check1("frame_done", dn_mask, 32'h8000_0000);

      // Beats after frame end without SOF are dropped.
      tu_mask = '0;
      for (int i = 0; i < 8; i++) begin
         beat(1'b1, 1'b0, 8'(33 + i));
         tu_mask[i] = m_tvalid;
      end
      check1("idle_drop", tu_mask, 32'd0);

      // Config change during a frame applies at the next SOF.
      beat(1'b1, 1'b1, 8'hA0);
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 8'(i));
      drive(0, 1, 1, 12'd4, 12'd2, 1, 0, 8'hA4);
      check1("pend_rows", {19'd0, pend, act_rows}, {19'd0, 1'b1, 12'd8});
      for (int i = 0; i < 27; i++) beat(1'b1, 1'b0, 8'(i));
      tl_mask = '0; dn_mask = '0;
      for (int i = 0; i < 8; i++) begin
         beat(1'b1, i == 0, 8'(i));
         tl_mask[i] = m_tlast; dn_mask[i] = fdone;
      end
      check1("small_tlast", tl_mask, 32'h88);
      check1("small_done", dn_mask, 32'h80);

      // Early SOF at beat 13 of an 8x4 frame.
      cfg(12'd8, 12'd4);
      dn_mask = '0;
      for (int i = 0; i < 12; i++) begin
         beat(1'b1, i == 0, 8'(i));
         dn_mask[i] = fdone;
      end
      beat(1'b1, 1'b1, 8'hEE);
      check1("early_sof", {29'd0, serr, m_tuser, m_tvalid}, 32'd7);
      for (int i = 1; i < 32; i++) begin
         beat(1'b1, 1'b0, 8'(i));
         if (i < 31) dn_mask[i] = fdone;
      end
      check1("no_abort_done", dn_mask, 32'd0);
      check1("restart_done", {31'd0, fdone}, 32'd1);

      // Illegal configs.
      cfg(12'd1, 12'd5);
      check1("cerr_rows", {30'd0, cerr, pend}, 32'd2);
      cfg(12'd6, 12'd0);
      check1("cerr_lines", {30'd0, cerr, pend}, 32'd2);

      // tvalid gaps, then reset mid-line.
      cfg(12'd4, 12'd2);
      for (int i = 0; i < 10; i++) begin
         beat(1'b1, i == 0, 8'(i));
         drive(0, 1, 0, 0, 0, 0, 0, 8'hFF);
      end
      beat(1'b1, 1'b0, 8'h55);
      drive(1, 1, 0, 0, 0, 1, 0, 8'h56);
      check("rst_state", dut_obs(), {7'd0, 12'd3840, 12'd2160, 8'd0});
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 8'(i));

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         logic r, wr, v, u;
         logic [11:0] rr, ll;
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         r  = ($urandom_range(0, 399) == 0);
         wr = ($urandom_range(0, 29) == 0);
         rr = 12'($urandom_range(0, 6));
         ll = 12'($urandom_range(0, 4));
         v  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 24) == 0) || (!m_in && $urandom_range(0, 3) == 0);
         drive(r, enable, wr, rr, ll, v, u, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
